fsm_narrow_to_wide: RTL
=======================

// Module: fsm_narrow_to_wide
// PURPOSE
//  Parametrised gearbox: packs RATIO beats of DIN_W bits into one DIN_W*RATIO word.
//  Adds a valid/ready handshake on both sides, a held output stage and flush of partial words.
//  Sits between the 64-bit host/DMA write path and wide miner-core inputs (e.g. 256-bit
//  midstate, 512-bit block header).
// PARAMETERS
//  DIN_W      64  input beat width, bits (>=8)
//  RATIO       4  beats per output word (>=2); DOUT_W = DIN_W*RATIO
//  MSB_FIRST   1  1: first beat -> dout[DOUT_W-1 -: DIN_W]; 0: first beat -> dout[DIN_W-1:0]
// PORTS
//  clk        in   1              clock
//  rst        in   1              asynchronous, active-low reset
//  we_in      in   1              input beat valid
//  ready_out  out  1              block can accept a beat this cycle
//  din        in   DIN_W          input beat
//  flush      in   1              emit current partial word (zero-padded)
//  we_out     out  1              output word valid
//  ready_in   in   1              downstream accepts word this cycle
//  dout       out  DOUT_W         packed output word
//  dout_beats out  CNT_W          valid beats in dout, 1..RATIO; CNT_W = $clog2(RATIO+1)
// BEHAVIOUR
//  - Reset (rst=0, async): cnt=0, acc=0, acc_full=0, we_out=0, dout=0, dout_beats=0.
//    ready_out=1 from the first cycle after release.
//  - Beat accepted on edge where we_in && ready_out. Beat k (k=cnt) lands in its slot:
//    MSB_FIRST ? acc[(RATIO-1-k)*DIN_W +: DIN_W] : acc[k*DIN_W +: DIN_W]. cnt increments.
//  - Word complete: accepted beat with cnt==RATIO-1.
//  - Transfer acc->output register on that edge if the output is free:
//    !we_out, or we_out && ready_in on the same edge.
//    Then we_out=1 with dout_beats=RATIO, and cnt=0, acc=0 on that edge.
//    Latency: last beat edge -> we_out high the following cycle (1 cycle).
//  - Output not free: acc_full=1, cnt held at RATIO, ready_out=0.
//    The transfer happens on the first edge where the output frees.
//    acc_full clears and ready_out returns to 1 the next cycle.
//  - ready_out = !acc_full (combinational from state, no din/we_in path).
//  - Output stage: dout/dout_beats/we_out stable while we_out && !ready_in.
//    They clear to we_out=0 on acceptance unless a new word transfers on the same edge,
//    giving back-to-back words, one per cycle at full rate.
//  - Full throughput: with ready_in=1, continuous we_in yields one word per RATIO cycles,
//    with no bubbles on the input.
//  - flush (sampled each edge, level):
//    * cnt>0 (beats pending, incl. a beat accepted this edge) and no full word completes:
//      pending beats transfer as a partial word, unused slots zero.
//      dout_beats = pending count. Same output-free rule as above; if the output is busy,
//      acc_full=1 and input stalls until transfer.
//    * Word completes on the same edge: normal full word, flush considered satisfied.
//    * cnt==0 and no beat accepted: no effect.
//  - Beat while acc_full: not accepted (ready_out=0); din ignored.
//  - Mid-operation reset: partial accumulator and held output discarded, no word emitted.
//  - dout_beats never 0 while we_out=1; cnt never exceeds RATIO.
// STRUCTURE
//  - Package gearbox_pkg:
//    * localparam function cnt_w(ratio) = $clog2(ratio+1)
//    * function slot_lsb(k, ratio, w, msb_first) returning the bit offset for beat k
//    * typedef enum {ACC_COLLECT, ACC_FULL} for the accumulator state
//  - One sub-module, gearbox_out_stage: DOUT_W+CNT_W wide valid/ready holding register.
//    Has load/free outputs; reused by the future 256->64 direction.
//  - Top: beat counter, slot-write decode, acc_full FSM, flush logic.
// TESTING (DIN_W=64, RATIO=4, MSB_FIRST=1 unless noted)
//  - Reset: rst=0 mid-run -> we_out=0, dout=0, ready_out=1 one cycle after release.
//    A word in flight is never emitted.
//  - Stream: 4 beats 0x11..,0x22..,0x33..,0x44.. with ready_in=1 -> one cycle after beat 4,
//    we_out=1 for 1 cycle, dout={0x11..,0x22..,0x33..,0x44..}, dout_beats=4.
//  - MSB_FIRST=0: same stimulus -> dout={0x44..,0x33..,0x22..,0x11..}.
//  - Backpressure: ready_in=0, stream 8 beats -> word1 held stable.
//    After beat 8, ready_out=0 and extra beats are rejected. Raise ready_in ->
//    word1 accepted, word2 appears the next cycle, ready_out=1 again.
//  - Flush: 2 beats A,B then flush -> dout={A,B,0,0}, dout_beats=2.
//    Flush with cnt==0 -> no word. Flush with beat 4 -> single full word, dout_beats=4.
//  - Throughput: 400 random beats, random ready_in -> scoreboard matches 100 words in order.
//    No beat lost or duplicated.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared types and helpers for the narrow/wide gearbox blocks.
package gearbox_pkg;

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int slot_lsb(input int k, input int ratio, input int w, input bit msb_first);
    return msb_first ? (ratio - 1 - k) * w : k * w;
  endfunction

  typedef enum logic {
    ACC_COLLECT,
    ACC_FULL
  } acc_state_e;

endpackage

// File: rtl/gearbox_out_stage.sv
// Valid/ready holding register; contents stay stable while valid and not accepted.
module gearbox_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready_in,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load is only legal when free, so it may overlap the acceptance of the held word.
  assign free  = !valid_q || ready_in;
  assign valid = valid_q;
  assign dout  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fsm_narrow_to_wide.sv
// Packs RATIO narrow beats into one wide word, with partial-word flush and a held output stage.
module fsm_narrow_to_wide
  import gearbox_pkg::*;
#(
  parameter  int DIN_W     = 64,
  parameter  int RATIO     = 4,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int DOUT_W    = DIN_W * RATIO,
  localparam int CNT_W     = cnt_w(RATIO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_in,
  output logic              ready_out,
  input  logic [DIN_W-1:0]  din,
  input  logic              flush,
  output logic              we_out,
  input  logic              ready_in,
  output logic [DOUT_W-1:0] dout,
  output logic [CNT_W-1:0]  dout_beats
);

  acc_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_wr;
  logic [DOUT_W-1:0]        acc_q, acc_d, acc_wr;
  logic                     accept, complete, emit, out_free, out_load;
  logic [DOUT_W+CNT_W-1:0]  out_data;

  assign ready_out = (state_q == ACC_COLLECT);
  assign accept    = we_in && ready_out;

  // Accumulator and count as they stand after this edge's beat, before any transfer.
  always_comb begin
    acc_wr = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (accept && cnt_q == CNT_W'(k))
        acc_wr[slot_lsb(k, RATIO, DIN_W, MSB_FIRST) +: DIN_W] = din;
    end
    cnt_wr = cnt_q + CNT_W'(accept);
  end

  // In ACC_FULL no beat is accepted, so acc_wr/cnt_wr equal the parked word.
  always_comb begin
    complete = accept && (cnt_q == CNT_W'(RATIO - 1));
    emit     = (state_q == ACC_FULL) || complete || (flush && cnt_wr != '0);
    out_load = emit && out_free;
    state_d  = state_q;
    cnt_d    = cnt_wr;
    acc_d    = acc_wr;
    if (out_load) begin
      state_d = ACC_COLLECT;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (emit) begin
      state_d = ACC_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACC_COLLECT;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  gearbox_out_stage #(
    .W (DOUT_W + CNT_W)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (out_load),
    .din      ({cnt_wr, acc_wr}),
    .ready_in (ready_in),
    .valid    (we_out),
    .dout     (out_data),
    .free     (out_free)
  );

  assign dout       = out_data[DOUT_W-1:0];
  assign dout_beats = out_data[DOUT_W+CNT_W-1:DOUT_W];

endmodule
